// File: rtl/fp_mant_div_nr.sv
// Sequential non-restoring mantissa divider: q = floor(a*2^(QW-1)/b) plus sticky,
// one quotient bit per cycle from a 27-bit add/subtract of the partial remainder.
module fp_mant_div_nr #(
   parameter int MW = 24,
   parameter int QW = 26
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [MW-1:0] a,
   input  logic [MW-1:0] b,
   output logic          busy,
   output logic          done,
   output logic [QW-1:0] q,
   output logic          sticky,
   output logic          dz
);

   localparam int RW = MW + 3;
   localparam int CW = $clog2(QW);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] r_q, r_d;
   logic [MW-1:0] b_q, b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [QW-1:0] q_q, q_d;
   logic          sticky_q, sticky_d;
   logic          dz_q, dz_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [RW-1:0] b_ext;
   logic [RW-1:0] r_shl;
   logic [RW-1:0] r_step;
   logic [RW-1:0] r_fix;
   logic [RW-1:0] r_init;
   logic          accept;

   // Remainder is two's complement; the divisor is always non-negative.
   assign b_ext  = {{(RW-MW){1'b0}}, b_q};
   assign r_shl  = {r_q[RW-2:0], 1'b0};
   assign r_step = r_q[RW-1] ? (r_shl + b_ext) : (r_shl - b_ext);
   assign r_fix  = r_q[RW-1] ? (r_q + b_ext) : r_q;
   assign r_init = {{(RW-MW){1'b0}}, a} - {{(RW-MW){1'b0}}, b};
   assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      state_d  = state_q;
      r_d      = r_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      q_d      = q_q;
      sticky_d = sticky_q;
      dz_d     = dz_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         S_ITER: begin
            r_d        = r_step;
            q_d[cnt_q] = ~r_step[RW-1];
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_FIX: begin
            r_d      = r_fix;
            sticky_d = |r_fix;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept) begin
         busy_d   = 1'b1;
         sticky_d = 1'b0;
         cnt_d    = CW'(QW - 2);
         if (b == '0) begin
            // Zero divisor passes through FIX with R=0 so done lands one edge after accept.
            state_d = S_FIX;
            r_d     = '0;
            b_d     = '0;
            q_d     = '1;
            dz_d    = 1'b1;
         end else begin
            state_d       = S_ITER;
            r_d           = r_init;
            b_d           = b;
            q_d           = '0;
            q_d[QW-1]     = ~r_init[RW-1];
            dz_d          = 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         r_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         q_q      <= '0;
         sticky_q <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         b_q      <= b_d;
         cnt_q    <= cnt_d;
         q_q      <= q_d;
         sticky_q <= sticky_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign q      = q_q;
   assign sticky = sticky_q;
   assign dz     = dz_q;

endmodule
